// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM state encoding,
// opcode/funct constants, ALU control encodings and the ALU operation class.
// MC_OVF_TRAP_EN adds the TRAP state used by the overflow trap.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_RTYPEWB,
        S_BEQEX,
        S_ADDIEX,
        S_ADDIWB,
`ifdef MC_OVF_TRAP_EN
        S_JEX,
        S_TRAP
`else
        S_JEX
`endif
    } state_e;

    // ALU operation class requested by the FSM; FUNCT defers to the funct field
    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_e;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    // R-type functions whose result can signal arithmetic overflow
    function automatic logic funct_can_ovf(input logic [5:0] f);
        return (f == FUNCT_ADD) || (f == FUNCT_SUB);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU control decoder: maps the FSM's ALU operation class and the
// instruction funct field to the 3-bit ALU control code.
module alu_dec
    import mc_pkg::*;
(
    input  aluop_e      aluop_i,
    input  logic [5:0]  funct_i,
    output logic [2:0]  alucontrol_o
);

    // Fixed add/sub for address and branch math, funct table for R-type
    always_comb begin
        alucontrol_o = ALUC_ADD;
        case (aluop_i)
            ALUOP_ADD: alucontrol_o = ALUC_ADD;
            ALUOP_SUB: alucontrol_o = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: alucontrol_o = ALUC_ADD;
                    FUNCT_SUB: alucontrol_o = ALUC_SUB;
                    FUNCT_AND: alucontrol_o = ALUC_AND;
                    FUNCT_OR:  alucontrol_o = ALUC_OR;
                    FUNCT_SLT: alucontrol_o = ALUC_SLT;
                    default:   alucontrol_o = ALUC_ADD;
                endcase
            end
            default: alucontrol_o = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM stepping each instruction through
// fetch/decode/execute/memory/writeback and driving all datapath enables and
// selects. Optional MC_OVF_TRAP_EN diverts overflowing add/sub/addi to a
// one-cycle TRAP that loads the exception vector instead of writing back.
module mc_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        overflow,
    output logic        pcen,
    output logic        iord,
    output logic        memwrite,
    output logic        irwrite,
    output logic        regwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [2:0]  alucontrol,
    output logic        exc
);

    state_e state_q, state_d;
    logic   pcwrite;
    logic   branch;
    aluop_e aluop;

`ifndef MC_OVF_TRAP_EN
    logic   ovf_unused;
    assign ovf_unused = overflow;
`endif

    // State register; reset returns to FETCH from any state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode; reset overrides everything at the end
    always_comb begin
        state_d  = state_q;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        aluop    = ALUOP_ADD;
        exc      = 1'b0;

        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
`ifdef MC_OVF_TRAP_EN
                state_d = (overflow && funct_can_ovf(funct)) ? S_TRAP : S_RTYPEWB;
`else
                state_d = S_RTYPEWB;
`endif
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
`ifdef MC_OVF_TRAP_EN
                state_d = overflow ? S_TRAP : S_ADDIWB;
`else
                state_d = S_ADDIWB;
`endif
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
`ifdef MC_OVF_TRAP_EN
            S_TRAP: begin
                exc     = 1'b1;
                pcsrc   = 2'b11;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase

        if (reset) begin
            state_d  = S_FETCH;
            iord     = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            regdst   = 1'b0;
            memtoreg = 1'b0;
            alusrca  = 1'b0;
            alusrcb  = 2'b00;
            pcsrc    = 2'b00;
            pcwrite  = 1'b0;
            branch   = 1'b0;
            aluop    = ALUOP_ADD;
            exc      = 1'b0;
        end
    end

    assign pcen = pcwrite | (branch & zero);

    alu_dec u_alu_dec (
        .aluop_i      (aluop),
        .funct_i      (funct),
        .alucontrol_o (alucontrol)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: reset behaviour, a directed table of
// instructions (cycle counts, execute-cycle ALU code and pcen), hand-written
// reset/abort sequences and randomized instruction streams checked per cycle
// against a per-instruction expected-cycle list.
module tb_mc_controller;

    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_UND  = 6'b111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, overflow;
    logic       pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       exc;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .overflow(overflow), .pcen(pcen), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst),
        .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .exc(exc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Output vector: {pcen,iord,memwrite,irwrite,regwrite,regdst,memtoreg,alusrca,alusrcb,pcsrc,alucontrol,exc}
    function automatic logic [15:0] outv();
        return {pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
                alusrcb, pcsrc, alucontrol, exc};
    endfunction

    function automatic logic [15:0] pk(input logic pe, input logic io, input logic mw,
                                       input logic irw, input logic rw, input logic rd,
                                       input logic mtr, input logic asa, input logic [1:0] asb,
                                       input logic [1:0] ps, input logic [2:0] alu, input logic ex);
        return {pe, io, mw, irw, rw, rd, mtr, asa, asb, ps, alu, ex};
    endfunction

    function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // ---------------- reference model: expected cycles of one instruction ----------------
    typedef struct {
        logic [15:0] v;
        bit          follows_zero;
    } cyc_t;

    cyc_t exp_q[$];

    task automatic push(input logic [15:0] v, input bit fz);
        cyc_t c;
        c.v = v;
        c.follows_zero = fz;
        exp_q.push_back(c);
    endtask

    task automatic build(input logic [5:0] o, input logic [5:0] f, input logic ovf);
        bit trap;
        trap = 1'b0;
`ifdef MC_OVF_TRAP_EN
        trap = ovf && ((o == T_ADDI) || (o == T_R && (f == 6'b100000 || f == 6'b100010)));
`else
        trap = ovf && 1'b0;
`endif
        exp_q.delete();
        push(pk(1,0,0,1,0,0,0,0,2'b01,2'b00,3'b010,0), 0);                      // fetch
        push(pk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0), 0);                      // decode
        case (o)
            T_LW: begin
                push(pk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0), 0);
                push(pk(0,1,0,0,0,0,0,0,2'b00,2'b00,3'b010,0), 0);
                push(pk(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b010,0), 0);
            end
            T_SW: begin
                push(pk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0), 0);
                push(pk(0,1,1,0,0,0,0,0,2'b00,2'b00,3'b010,0), 0);
            end
            T_R: begin
                push(pk(0,0,0,0,0,0,0,1,2'b00,2'b00,alu_of_funct(f),0), 0);
                if (trap) push(pk(1,0,0,0,0,0,0,0,2'b00,2'b11,3'b010,1), 0);
                else      push(pk(0,0,0,0,1,1,0,0,2'b00,2'b00,3'b010,0), 0);
            end
            T_BEQ:
                push(pk(0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0), 1);
            T_ADDI: begin
                push(pk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0), 0);
                if (trap) push(pk(1,0,0,0,0,0,0,0,2'b00,2'b11,3'b010,1), 0);
                else      push(pk(0,0,0,0,1,0,0,0,2'b00,2'b00,3'b010,0), 0);
            end
            T_J:
                push(pk(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,0), 0);
            default: ;
        endcase
    endtask

    // Entered at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic ovf);
        logic [15:0] e;
        build(o, f, ovf);
        op = o;
        funct = f;
        overflow = ovf;
        foreach (exp_q[i]) begin
            zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            e = exp_q[i].v;
            if (exp_q[i].follows_zero) e[15] = zero;
            check($sformatf("op%b_f%b_cyc%0d", o, f, i), {16'h0, outv()}, {16'h0, e});
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       ovf;
        int         cycles;
        logic [2:0] ex_alu;
        logic       ex_pcen;
    } vec_t;

    vec_t tv[$];

    localparam logic [15:0] RST_V = 16'h0004;   // all zero, alucontrol 010

    initial begin
        int idx;
        bit done;
        logic [2:0] alu_seen;
        logic       pcen_seen;
        logic [5:0] ro, rf;

        tv.push_back('{T_LW,   6'b000000, 1'b0, 1'b0, 5, 3'b010, 1'b0});
        tv.push_back('{T_SW,   6'b000000, 1'b0, 1'b0, 4, 3'b010, 1'b0});
        tv.push_back('{T_R,    6'b101010, 1'b0, 1'b0, 4, 3'b111, 1'b0});
        tv.push_back('{T_R,    6'b100000, 1'b1, 1'b0, 4, 3'b010, 1'b0});
        tv.push_back('{T_R,    6'b100010, 1'b0, 1'b0, 4, 3'b110, 1'b0});
        tv.push_back('{T_R,    6'b100100, 1'b0, 1'b0, 4, 3'b000, 1'b0});
        tv.push_back('{T_R,    6'b100101, 1'b0, 1'b0, 4, 3'b001, 1'b0});
        tv.push_back('{T_R,    6'b000111, 1'b0, 1'b0, 4, 3'b010, 1'b0});
        tv.push_back('{T_BEQ,  6'b000000, 1'b1, 1'b0, 3, 3'b110, 1'b1});
        tv.push_back('{T_BEQ,  6'b000000, 1'b0, 1'b0, 3, 3'b110, 1'b0});
        tv.push_back('{T_ADDI, 6'b000000, 1'b0, 1'b0, 4, 3'b010, 1'b0});
        tv.push_back('{T_ADDI, 6'b000000, 1'b0, 1'b1, 4, 3'b010, 1'b0});
        tv.push_back('{T_J,    6'b000000, 1'b0, 1'b0, 3, 3'b010, 1'b1});
        tv.push_back('{T_UND,  6'b000000, 1'b0, 1'b0, 2, 3'b010, 1'b0});

        // reset held for two edges, outputs forced while high
        reset = 1'b1; op = T_LW; funct = 6'b0; zero = 1'b1; overflow = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_hold1", {16'h0, outv()}, {16'h0, RST_V});
        @(posedge clk); #1;
        reset = 1'b0;

        // lw straight out of reset, then the directed table
        run_instr(T_LW, 6'b000000, 1'b0);

        foreach (tv[k]) begin
            op = tv[k].op; funct = tv[k].funct; zero = tv[k].zero; overflow = tv[k].ovf;
            idx = 1;
            done = 1'b0;
            alu_seen = 3'bxxx;
            pcen_seen = 1'bx;
            @(posedge clk); #1;
            while (!done && idx < 10) begin
                @(negedge clk);
                if (irwrite) done = 1'b1;
                else begin
                    if (idx == 2) begin
                        alu_seen = alucontrol;
                        pcen_seen = pcen;
                    end
                    idx++;
                    @(posedge clk); #1;
                end
            end
            check($sformatf("cycles_op%b_f%b", tv[k].op, tv[k].funct),
                  done ? idx : 99, tv[k].cycles);
            if (tv[k].cycles > 2) begin
                check($sformatf("exalu_op%b_f%b", tv[k].op, tv[k].funct),
                      {29'h0, alu_seen}, {29'h0, tv[k].ex_alu});
                check($sformatf("expcen_op%b_z%b", tv[k].op, tv[k].zero),
                      {31'h0, pcen_seen}, {31'h0, tv[k].ex_pcen});
            end
        end

        // now mid-FETCH: reset here, outputs forced immediately
        reset = 1'b1;
        #1;
        check("reset_in_fetch", {16'h0, outv()}, {16'h0, RST_V});
        @(posedge clk); #1;
        reset = 1'b0;

        // abort an R-type in RTYPEEX: no writeback afterwards
        op = T_R; funct = 6'b100000; overflow = 1'b0; zero = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rtypeex_before_reset", {16'h0, outv()},
              {16'h0, pk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010,0)});
        reset = 1'b1;
        #1;
        check("reset_in_rtypeex", {16'h0, outv()}, {16'h0, RST_V});
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(T_UND, 6'b000000, 1'b0);

        // back-to-back sw then j, and addi with overflow
        run_instr(T_SW, 6'b000000, 1'b0);
        run_instr(T_J, 6'b000000, 1'b0);
        run_instr(T_ADDI, 6'b000000, 1'b1);
        run_instr(T_R, 6'b100010, 1'b1);
        run_instr(T_BEQ, 6'b000000, 1'b0);

        // randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0: ro = T_LW;
                1: ro = T_SW;
                2: ro = T_R;
                3: ro = T_BEQ;
                4: ro = T_ADDI;
                5: ro = T_J;
                default: begin
                    ro = 6'($urandom_range(0, 63));
                    if (ro == T_LW || ro == T_SW || ro == T_R || ro == T_BEQ ||
                        ro == T_ADDI || ro == T_J) ro = T_UND;
                end
            endcase
            case ($urandom_range(0, 6))
                0: rf = 6'b100000;
                1: rf = 6'b100010;
                2: rf = 6'b100100;
                3: rf = 6'b100101;
                4: rf = 6'b101010;
                default: rf = 6'($urandom_range(0, 63));
            endcase
            run_instr(ro, rf, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
